// File: rtl/display_scan4_if.sv
// ============================================================================
// Module   : display_scan4_if
// Brief    : Bundles the value/control inputs and the scan outputs of the
//            four-digit display scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface display_scan4_if;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_in;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;

    modport master (
        output value_in, load, blank_lz, dp_in,
        input  bcd_out, an, dp, digit_idx
    );

    modport slave (
        input  value_in, load, blank_lz, dp_in,
        output bcd_out, an, dp, digit_idx
    );
endinterface

`default_nettype wire

// File: rtl/display_scan4.sv
// ============================================================================
// Module   : display_scan4
// Brief    : Four-digit time-multiplexed display scanner with frame-aligned
//            value update, leading-zero blanking and decimal points.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_scan4 #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    display_scan4_if.slave   bus
);

    localparam int unsigned      PCNT_W = 24;
    localparam logic [PCNT_W-1:0] C_PMAX = PCNT_W'(REFRESH_DIV - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       pending_q, pending_d;
    logic [15:0]       active_q, active_d;
    logic [3:0]        bcd_q, bcd_d;
    logic [3:0]        an_q, an_d;
    logic              dp_q, dp_d;

    logic              tick;
    logic              frame_end;
    logic [3:0]        blanked;
    logic [3:0]        nib_cur;

    always_comb begin
        tick      = (pcnt_q == C_PMAX);
        frame_end = tick && (idx_q == 2'd3);

        // A digit is blank only if it and every digit to its left is zero.
        blanked    = 4'b0000;
        blanked[3] = bus.blank_lz && (active_q[15:12] == 4'h0);
        blanked[2] = blanked[3]   && (active_q[11:8]  == 4'h0);
        blanked[1] = blanked[2]   && (active_q[7:4]   == 4'h0);

        nib_cur = active_q[{idx_q, 2'b00} +: 4];

        pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        pending_d = bus.load ? bus.value_in : pending_q;
        active_d  = active_q;
        // A load coinciding with the boundary bypasses pending so it is not lost for a frame.
        if (frame_end) begin
            active_d = bus.load ? bus.value_in : pending_q;
        end

        bcd_d = nib_cur;
        an_d  = blanked[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
        dp_d  = blanked[idx_q] | ~bus.dp_in[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q    <= '0;
            idx_q     <= 2'd0;
            pending_q <= 16'h0000;
            active_q  <= 16'h0000;
            bcd_q     <= 4'h0;
            an_q      <= 4'b1110;
            dp_q      <= 1'b1;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            bcd_q     <= bcd_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.an        = an_q;
    assign bus.dp        = dp_q;
    assign bus.digit_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan4.sv
// ============================================================================
// Module   : tb_display_scan4
// Brief    : Self-checking bench for display_scan4 using an expected-output
//            queue fed from a cycle-count based reference of the scan timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_scan4;

    localparam int R = 4;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [15:0] pend_m;
    logic [15:0] act_m;
    exp_t sb[$];

    display_scan4_if bus ();

    display_scan4 #(.REFRESH_DIV(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected outputs after a clock edge: the displayed slot is the digit
    // index held before that edge; digit_idx is the index after it.
    function automatic exp_t expect_out(logic [15:0] act, int k, logic blank,
                                        logic [3:0] dpi, int idx_now);
        exp_t       e;
        logic       blk;
        logic [3:0] one;
        one   = 4'b0001;
        blk   = blank && (k >= 1) && ((act >> (4 * k)) == 16'h0000);
        e.bcd = act[4 * k +: 4];
        e.an  = blk ? 4'b1111 : ~(one << k);
        e.dp  = blk ? 1'b1 : ~dpi[k];
        e.idx = 2'(idx_now);
        return e;
    endfunction

    task automatic step();
        int   n;
        exp_t e;
        exp_t got;
        n = cyc + 1;
        e = expect_out(act_m, ((n - 1) / R) % 4, bus.blank_lz, bus.dp_in, (n / R) % 4);
        sb.push_back(e);
        if ((n % R == 0) && ((n / R) % 4 == 0)) act_m = bus.load ? bus.value_in : pend_m;
        if (bus.load) pend_m = bus.value_in;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        got = {bus.bcd_out, bus.an, bus.dp, bus.digit_idx};
        e   = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL scan cyc=%0d: got bcd=%h an=%b dp=%b idx=%0d, expected bcd=%h an=%b dp=%b idx=%0d",
                     cyc, got.bcd, got.an, got.dp, got.idx, e.bcd, e.an, e.dp, e.idx);
        end
    endtask

    task automatic load_step(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic run_to_idx(input int k);
        for (int i = 0; i < 4 * R && ((cyc / R) % 4) != k; i++) step();
    endtask

    // Leaves the bench positioned so the next edge is the 3 -> 0 tick.
    task automatic run_to_boundary();
        for (int i = 0; i < 4 * R && ((cyc + 1) % (4 * R)) != 0; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [10:0] got;
        got = {bus.bcd_out, bus.an, bus.dp, bus.digit_idx};
        checks++;
        if (got !== {4'h0, 4'b1110, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL %s: got bcd=%h an=%b dp=%b idx=%0d, expected bcd=0 an=1110 dp=1 idx=0",
                     tag, bus.bcd_out, bus.an, bus.dp, bus.digit_idx);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst    = 1'b0;
        cyc    = 0;
        pend_m = 16'h0000;
        act_m  = 16'h0000;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_initial");
        release_reset();
        load_step(16'h1234);
        run(4 * R - 1);
        run_to_idx(2);
        run(1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_async_midframe");
        release_reset();
        run(R - 1);
        checks++;
        if (bus.digit_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_tick_early: got idx=%0d, expected 0", bus.digit_idx);
        end
        run(1);
        checks++;
        if (bus.digit_idx !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_tick: got idx=%0d, expected 1", bus.digit_idx);
        end
    endtask

    task automatic test_scan();
        load_step(16'h1234);
        run_to_boundary();
        run(3 * 4 * R);
    endtask

    task automatic test_anti_tear();
        run_to_idx(1);
        load_step(16'hABCD);
        run(2 * 4 * R);
    endtask

    task automatic test_boundary_load();
        run_to_boundary();
        load_step(16'h5678);
        run(4 * R + 2);
        load_step(16'h1111);
        run(R);
        load_step(16'h2222);
        run(2 * 4 * R);
    endtask

    task automatic test_blank();
        bus.blank_lz = 1'b1;
        load_step(16'h0050);
        run(2 * 4 * R);
        load_step(16'h0000);
        run(2 * 4 * R);
        bus.blank_lz = 1'b0;
        run(4 * R);
    endtask

    task automatic test_dp();
        bus.dp_in = 4'b0101;
        load_step(16'h1234);
        run(2 * 4 * R);
        bus.blank_lz = 1'b1;
        load_step(16'h0004);
        run(2 * 4 * R);
        bus.blank_lz = 1'b0;
        bus.dp_in    = 4'b0000;
        run(R);
    endtask

    initial begin
        rst          = 1'b1;
        bus.value_in = 16'h0000;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_in    = 4'b0000;
        pend_m       = 16'h0000;
        act_m        = 16'h0000;
        test_reset();
        test_scan();
        test_anti_tear();
        test_boundary_load();
        test_blank();
        test_dp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan4.md
# display_scan4

Four-digit time-multiplexed display scanner placed directly upstream of the BCD-to-seven-segment decoder. It holds a 16-bit packed value of four 4-bit digits and cycles through the digits at a programmable refresh rate. On each step it presents one nibble on `bcd_out` for the decoder and drives the matching active-low anode. New values are latched at frame boundaries only, so a display refresh never shows a mix of old and new digits. Optional leading-zero blanking is provided.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is 1 to 2^24-1.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `value_in`, in, 16: packed digits. Bits [3:0] are digit 0 (rightmost) and bits [15:12] are digit 3.
- `load`, in, 1: one-cycle strobe that captures `value_in`.
- `blank_lz`, in, 1: leading-zero blanking enable. It is sampled live and is not latched.
- `dp_in`, in, 4: decimal point request per digit. Bit k maps to digit k, 1 = point lit. Sampled live.
- `bcd_out`, out, 4: nibble for the current digit, wired to the decoder input.
- `an`, out, 4: anode enables, active-low. Bit k drives digit k.
- `dp`, out, 1: decimal point segment, active-low.
- `digit_idx`, out, 2: index of the digit currently being scanned.

## Operation
- Prescaler `pcnt` counts 0 to REFRESH_DIV-1 and wraps.
  - `tick` is asserted in the cycle where pcnt == REFRESH_DIV-1.
  - With REFRESH_DIV = 1, `tick` is asserted every cycle.
- `digit_idx` advances on each `tick`: 0 → 1 → 2 → 3 → 0.
  - The tick that moves 3 → 0 is the frame boundary.
- Registers: `pending` (16 bits) and `active` (16 bits).
  - `load` writes `value_in` into `pending`. If several loads occur within one frame, the last one wins.
  - At the frame boundary, `active` takes `value_in` if `load` is asserted in that same cycle; otherwise it takes `pending`.
  - `pending` keeps its value after the transfer, so an unchanged value is simply re-displayed.
- Digit nibble: `nib[k] = active[4k+3:4k]`. Values 10–15 pass through unchanged; the decoder shows them as hex.
- Blanking:
  - Digit k (k ≥ 1) is blanked when `blank_lz` = 1 and nib[k..3] are all zero.
  - Digit 0 is never blanked.
- Registered outputs, computed from the current `digit_idx` and `active`:
  - `bcd_out` = nib[idx].
  - `an` = all ones except bit idx = 0. If the digit is blanked, `an` = 4'b1111.
  - `dp` = ~dp_in[idx]. `dp` is forced to 1 when the digit is blanked.
- Only one anode is ever low at a time.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - pcnt = 0, digit_idx = 0, pending = 0, active = 0.
  - bcd_out = 4'h0, an = 4'b1110, dp = 1.
- After `rst` is released, the first tick occurs on the REFRESH_DIV-th rising edge.
- Pipeline timing:
  - `digit_idx` and `active` update on the tick edge.
  - `bcd_out`, `an` and `dp` reflect them one cycle later, i.e. a fixed latency of 1 clock.
- Each digit slot lasts exactly REFRESH_DIV cycles. A frame is 4 × REFRESH_DIV cycles.
- Load-to-display latency:
  - The value appears at the next frame boundary plus 1 cycle.
  - Worst case is 4 × REFRESH_DIV + 1 cycles.
- A `load` in the same cycle as a non-boundary tick only updates `pending`. The rest of the current frame keeps the old value.
- `blank_lz` and `dp_in` changes take effect on the next output register update, at most 1 cycle later.

## Test plan
- Reset: with REFRESH_DIV = 4, assert `rst` while digit_idx = 2.
  - Expect an = 4'b1110, bcd_out = 0, dp = 1, digit_idx = 0 immediately, without waiting for a clock edge.
  - After release, digit_idx = 1 appears 4 cycles later.
- Scan: REFRESH_DIV = 4, load 16'h1234, wait for the frame boundary.
  - bcd_out runs 4, 3, 2, 1, each held for 4 cycles.
  - an runs 1110, 1101, 1011, 0111 in step with bcd_out.
  - The pattern repeats every 16 cycles.
- Anti-tearing: while displaying 16'h1234, load 16'hABCD with digit_idx = 1.
  - Digits 2 and 3 still show 2 and 1.
  - The next frame shows D, C, B, A.
- Boundary load: load 16'h5678 in the exact cycle of the 3 → 0 tick.
  - Digit 0 of that same frame shows 8.
  - Two loads within one frame (16'h1111 then 16'h2222): the next frame shows only 2.
- Blanking: blank_lz = 1, value 16'h0050.
  - Digits 3 and 2 give an = 1111.
  - Digit 1 shows 5 with an = 1101.
  - Digit 0 shows 0 with an = 1110.
  - With value 16'h0000, only digit 0 is lit.
  - With blank_lz = 0, all four digits are lit.
- Decimal point: dp_in = 4'b0101, value 16'h1234.
  - dp = 0 only in the digit 0 and digit 2 slots.
  - With blank_lz = 1 and value 16'h0004, dp stays 1 during the blanked digit 2 slot.
